avr_hvpp_sequencer: RTL and testbench
=====================================

Name: avr_hvpp_sequencer

Overview:
- Parametrised, clocked successor to the first-generation AVR high-voltage parallel-programming bottom half.
- Host software no longer toggles XTAL, WR, OE and PAGEL one register write at a time. The host issues whole commands (LOAD, PAGEL, PROG, READ), and this block generates the DUT strobe timing itself.
- PROG waits on RDY/BSY with a timeout; READ captures DUT data on a timed strobe.
- Sits between the host register decoder and the ZIF pin drivers.

Parameters:
- DATA_W, 8: DUT data bus width.
- SETUP, 2: cycles control/data are stable before a strobe asserts (min 1).
- PULSE, 4: strobe active width in cycles for XTAL, PAGEL and WR (min 1).
- SETTLE, 4: cycles from OE_n low to data capture (min 2).
- TO_W, 16: width of the timeout counter.
- TIMEOUT, 50000: maximum RDY wait in cycles (must be less than 2^TO_W).

Ports:
- osc_in  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle; accepts a command
- cmd_op  in  2  00 LOAD, 01 PAGEL, 10 PROG, 11 READ
- cmd_xa  in  2  {XA1,XA0} for the command
- cmd_bs  in  2  {BS2,BS1} for the command
- cmd_data  in  DATA_W  data for LOAD
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_W  READ result; holds until the next READ completes
- rsp_timeout  out  1  PROG completed by timeout; valid with rsp_valid
- busy  out  1  equals not cmd_ready
- dut_data_o  out  DATA_W  data driven to DUT
- dut_data_oe  out  1  FPGA drives the DUT data pins
- dut_data_i  in  DATA_W  DUT data pins
- dut_rdy  in  1  DUT RDY/BSY, asynchronous
- dut_xtal, dut_pagel  out  1  active-high strobes
- dut_wr_n, dut_oe_n  out  1  active-low strobes
- dut_bs1, dut_bs2, dut_xa0, dut_xa1  out  1  mode selects

Behaviour:
- Interface: one clock, osc_in. Reset rst is synchronous and active-high.
- Reset state, entered immediately even mid-command, with no rsp_valid issued for the aborted command:
  - FSM=IDLE, cmd_ready=1.
  - dut_wr_n=1, dut_oe_n=1, dut_xtal=0, dut_pagel=0.
  - bs/xa outputs=0, dut_data_oe=0, dut_data_o=0.
  - rsp_valid=0, rsp_timeout=0, rsp_data=0.
  - RDY synchroniser flops=0, counters=0.
- Handshake:
  - Accept occurs when cmd_valid && cmd_ready, in cycle T.
  - cmd_ready=1 only in IDLE; cmd_valid while busy is ignored (not queued).
  - The cycle after accept, all command fields are registered and bs/xa outputs update.
- FSM states: IDLE, SETUP, STROBE, RDY_WAIT, SETTLE, DONE.
  - DONE lasts one cycle with rsp_valid=1, then IDLE. The next accept is possible at DONE+1.
- Counter rule: each timed state runs its counter from N-1 down to 0, then advances.
- LOAD:
  - T+1: dut_data_o=cmd_data, dut_data_oe=1.
  - SETUP cycles, then STROBE with dut_xtal=1 for PULSE cycles, then DONE with xtal=0.
  - Latency accept-to-rsp_valid = SETUP+PULSE+1 (7 at defaults).
  - dut_data_oe stays 1 after LOAD until a READ starts.
- PAGEL: same as LOAD, with dut_pagel as the strobe; data/oe unchanged.
- PROG:
  - SETUP, then dut_wr_n=0 for PULSE cycles, then RDY_WAIT.
  - dut_rdy passes a 2-flop synchroniser. RDY_WAIT ignores the first 2 cycles (blanking) before it samples the synced RDY.
  - Exits to DONE on synced RDY=1 with rsp_timeout=0.
  - Exits to DONE when the wait counter reaches TIMEOUT with rsp_timeout=1.
  - RDY high and counter==TIMEOUT in the same cycle resolves as success (rsp_timeout=0).
- READ:
  - T+1: dut_data_oe=0 and dut_oe_n=1 (dead cycle).
  - T+2: dut_oe_n=0, enter SETTLE for SETTLE cycles.
  - On the final SETTLE cycle, rsp_data<=dut_data_i.
  - DONE: dut_oe_n=1.
  - Latency accept-to-rsp_valid = SETTLE+2.
- Contention invariant: dut_data_oe and !dut_oe_n are never both 1 in any cycle.
- rsp_timeout is cleared on the next accept; rsp_data is held otherwise.

Test Plan:
- Reset then LOAD xa=00, bs=00, data=0xA5 -> dut_data_o=0xA5 and oe=1 from T+1; xtal high cycles T+3..T+6; rsp_valid at T+7.
- PROG with dut_rdy falling at T+4 and rising at T+40 -> wr_n low T+3..T+6; rsp_valid ~T+43 (2-cycle sync plus DONE); rsp_timeout=0.
- PROG with dut_rdy stuck low, TIMEOUT=100 -> rsp_valid with rsp_timeout=1 after 100 wait cycles; the next LOAD clears rsp_timeout.
- READ after LOAD with dut_data_i=0x3C -> oe pins released T+1; oe_n low T+2..T+5; rsp_data=0x3C at rsp_valid T+6; no cycle with oe and !oe_n both asserted.
- rst asserted during PROG RDY_WAIT -> next cycle all outputs at reset values, no rsp_valid; cmd_valid held high throughout -> new accept on the first post-reset cycle.
- Back-to-back: cmd_valid held high with PAGEL then READ -> second accept exactly at DONE+1; cmd_ready low during the whole first command.

Source files
------------

// File: rtl/avr_hvpp_sequencer.sv
// AVR HVPP command sequencer: turns LOAD/PAGEL/PROG/READ commands
// into timed XTAL/PAGEL/WR/OE strobes for the target's programming pins.
//
// Ports:
//   osc_in, rst           clock, synchronous active-high reset
//   cmd_*                 command handshake and fields from the host
//   rsp_*                 one-cycle completion pulse, READ data, PROG timeout
//   busy                  inverse of cmd_ready
//   dut_data_o/_oe/_i     target data bus (drive, drive enable, sample)
//   dut_rdy               target RDY/BSY, asynchronous
//   dut_xtal/pagel/wr_n/oe_n, dut_bs1/bs2/xa0/xa1   target control pins
`timescale 1ns/1ps
module avr_hvpp_sequencer #(
  parameter int DATA_W  = 8,
  parameter int SETUP   = 2,
  parameter int PULSE   = 4,
  parameter int SETTLE  = 4,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic              osc_in,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_xa,
  input  logic [1:0]        cmd_bs,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [DATA_W-1:0] dut_data_o,
  output logic              dut_data_oe,
  input  logic [DATA_W-1:0] dut_data_i,
  input  logic              dut_rdy,
  output logic              dut_xtal,
  output logic              dut_pagel,
  output logic              dut_wr_n,
  output logic              dut_oe_n,
  output logic              dut_bs1,
  output logic              dut_bs2,
  output logic              dut_xa0,
  output logic              dut_xa1
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_PAGEL = 2'b01;
  localparam logic [1:0] OP_PROG  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam int M1 = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int CMAX = (M1 > SETTLE) ? M1 : SETTLE;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RDY_WAIT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [1:0]        op_q;
  logic [1:0]        xa_q;
  logic [1:0]        bs_q;
  logic [DATA_W-1:0] data_q;
  logic              oe_q;
  logic              to_q;
  logic [DATA_W-1:0] rd_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_init;
  logic [TO_W-1:0]   wcnt;
  logic              rdy_s1;
  logic              rdy_s2;
  logic              accept;
  logic [1:0]        op_sel;
  logic              rdy_ok;
  logic              to_hit;

  assign accept = cmd_valid && (state == S_IDLE);
  assign op_sel = (state == S_IDLE) ? cmd_op : op_q;

  // RDY is blanked for the first two wait cycles; on the last
  // wait cycle a ready target still wins over the timeout.
  assign rdy_ok = rdy_s2 && (wcnt >= TO_W'(2));
  assign to_hit = (wcnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge osc_in) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:     if (cmd_valid) state_n = S_SETUP;
      S_SETUP:    if (cnt == '0)
                    state_n = (op_q == OP_READ) ? S_SETTLE : S_STROBE;
      S_STROBE:   if (cnt == '0)
                    state_n = (op_q == OP_PROG) ? S_RDY_WAIT : S_DONE;
      S_RDY_WAIT: if (rdy_ok || to_hit) state_n = S_DONE;
      S_SETTLE:   if (cnt == '0) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    dut_xtal  = 1'b0;
    dut_pagel = 1'b0;
    dut_wr_n  = 1'b1;
    dut_oe_n  = 1'b1;
    unique case (state)
      S_IDLE:   cmd_ready = 1'b1;
      S_STROBE: begin
        dut_xtal  = (op_q == OP_LOAD);
        dut_pagel = (op_q == OP_PAGEL);
        dut_wr_n  = (op_q != OP_PROG);
      end
      S_SETTLE: dut_oe_n = 1'b0;
      S_DONE:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // READ spends a single SETUP cycle as the bus-turnaround dead cycle.
  always_comb begin
    cnt_init = '0;
    unique case (state_n)
      S_SETUP:  cnt_init = (op_sel == OP_READ) ? '0 : CW'(SETUP - 1);
      S_STROBE: cnt_init = CW'(PULSE - 1);
      S_SETTLE: cnt_init = CW'(SETTLE - 1);
      default:  cnt_init = '0;
    endcase
  end

  always_ff @(posedge osc_in) begin
    if (rst) begin
      cnt  <= '0;
      wcnt <= '0;
    end else begin
      if (state_n != state) cnt <= cnt_init;
      else if (cnt != '0)   cnt <= cnt - CW'(1);
      if (state != S_RDY_WAIT) wcnt <= '0;
      else                     wcnt <= wcnt + TO_W'(1);
    end
  end

  always_ff @(posedge osc_in) begin
    if (rst) begin
      rdy_s1 <= 1'b0;
      rdy_s2 <= 1'b0;
      op_q   <= '0;
      xa_q   <= '0;
      bs_q   <= '0;
      data_q <= '0;
      oe_q   <= 1'b0;
      to_q   <= 1'b0;
      rd_q   <= '0;
    end else begin
      rdy_s1 <= dut_rdy;
      rdy_s2 <= rdy_s1;
      if (accept) begin
        op_q <= cmd_op;
        xa_q <= cmd_xa;
        bs_q <= cmd_bs;
        to_q <= 1'b0;
        if (cmd_op == OP_LOAD) begin
          data_q <= cmd_data;
          oe_q   <= 1'b1;
        end
        if (cmd_op == OP_READ) oe_q <= 1'b0;
      end
      if (state == S_RDY_WAIT && !rdy_ok && to_hit)
        to_q <= 1'b1;
      if (state == S_SETTLE && cnt == '0)
        rd_q <= dut_data_i;
    end
  end

  assign busy        = !cmd_ready;
  assign rsp_data    = rd_q;
  assign rsp_timeout = to_q;
  assign dut_data_o  = data_q;
  assign dut_data_oe = oe_q;
  assign dut_bs1     = bs_q[0];
  assign dut_bs2     = bs_q[1];
  assign dut_xa0     = xa_q[0];
  assign dut_xa1     = xa_q[1];

endmodule

// File: tb/tb_avr_hvpp_sequencer.sv
// Testbench for avr_hvpp_sequencer: directed command table,
// mid-command reset, and random commands against a timeline model.
`timescale 1ns/1ps
module tb_avr_hvpp_sequencer;

  localparam int DW = 8;
  localparam int SU = 2;
  localparam int PW = 4;
  localparam int ST = 4;
  localparam int TOUT = 100;
  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] PAGEL = 2'b01;
  localparam logic [1:0] PROG  = 2'b10;
  localparam logic [1:0] READ  = 2'b11;

  logic osc_in = 1'b0;
  always #5 osc_in = ~osc_in;

  logic rst, cmd_valid, cmd_ready;
  logic [1:0] cmd_op, cmd_xa, cmd_bs;
  logic [DW-1:0] cmd_data, rsp_data, dut_data_o, dut_data_i;
  logic rsp_valid, rsp_timeout, busy, dut_data_oe, dut_rdy;
  logic dut_xtal, dut_pagel, dut_wr_n, dut_oe_n;
  logic dut_bs1, dut_bs2, dut_xa0, dut_xa1;

  avr_hvpp_sequencer #(
    .DATA_W(DW), .SETUP(SU), .PULSE(PW), .SETTLE(ST),
    .TO_W(16), .TIMEOUT(TOUT)
  ) dut (
    .osc_in(osc_in), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_xa(cmd_xa), .cmd_bs(cmd_bs),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .dut_data_o(dut_data_o), .dut_data_oe(dut_data_oe),
    .dut_data_i(dut_data_i), .dut_rdy(dut_rdy),
    .dut_xtal(dut_xtal), .dut_pagel(dut_pagel),
    .dut_wr_n(dut_wr_n), .dut_oe_n(dut_oe_n),
    .dut_bs1(dut_bs1), .dut_bs2(dut_bs2),
    .dut_xa0(dut_xa0), .dut_xa1(dut_xa1)
  );

  int checks = 0;
  int errors = 0;

  // Model of the programmer-visible registers.
  logic          m_oe, m_to;
  logic [DW-1:0] m_do, m_rd;
  logic [1:0]    m_xa, m_bs;

  typedef struct {
    logic [1:0] op;
    logic [1:0] xa;
    logic [1:0] bs;
    logic [7:0] data;
    logic [7:0] din;
    int         fall;
    int         rise;
    bit         hold;
    int         lat;
    bit         to;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_oe = 0; m_to = 0; m_do = '0; m_rd = '0; m_xa = '0; m_bs = '0;
  endtask

  // Target RDY level during relative cycle k of a command.
  function automatic bit rdyv(int k, int fall, int rise);
    return (k < fall) || (k >= rise);
  endfunction

  // Completion cycle and timeout flag derived from the timing rules.
  task automatic model(input logic [1:0] op, input int fall, input int rise,
                       output int lat, output bit to);
    int w0;
    to = 0;
    lat = 0;
    case (op)
      READ: lat = ST + 2;
      PROG: begin
        w0 = SU + PW + 1;
        lat = w0 + TOUT;
        to = 1;
        for (int k = w0; k < w0 + TOUT; k++) begin
          // synced RDY lags the pin by two cycles; first two ignored
          if ((k - w0) >= 2 && rdyv(k - 2, fall, rise)) begin
            lat = k + 1;
            to = 0;
            break;
          end
        end
      end
      default: lat = SU + PW + 1;
    endcase
  endtask

  task automatic check_vec(string tag, int k, int lat, logic [1:0] op);
    logic [28:0] exp, got;
    bit er, rv, str, xt, pg, wrn, oen;
    er  = (k == 0) || (k > lat);
    rv  = (k == lat) && (k > 0);
    str = (k >= SU + 1) && (k <= SU + PW) && (k <= lat) && (op != READ);
    xt  = str && (op == LOAD);
    pg  = str && (op == PAGEL);
    wrn = !(str && (op == PROG));
    oen = !((op == READ) && (k >= 2) && (k <= ST + 1) && (k <= lat));
    exp = {er, !er, rv, m_to, m_rd, m_do, m_oe, xt, pg, wrn, oen,
           m_bs[0], m_bs[1], m_xa[0], m_xa[1]};
    got = {cmd_ready, busy, rsp_valid, rsp_timeout, rsp_data, dut_data_o,
           dut_data_oe, dut_xtal, dut_pagel, dut_wr_n, dut_oe_n,
           dut_bs1, dut_bs2, dut_xa0, dut_xa1};
    chk($sformatf("%s k=%0d outputs", tag, k), 32'(got), 32'(exp));
    chk($sformatf("%s k=%0d contention", tag, k),
        32'(dut_data_oe & ~dut_oe_n), 32'd0);
  endtask

  // Entered just after a rising edge; leaves at the falling edge of
  // the last checked cycle.
  task automatic run_cmd(string tag, vec_t v, int gap, int abort_k);
    int lat, obs;
    bit to;
    model(v.op, v.fall, v.rise, lat, to);
    cmd_op = v.op; cmd_xa = v.xa; cmd_bs = v.bs;
    cmd_data = v.data; dut_data_i = v.din;
    cmd_valid = 1; dut_rdy = 1;
    @(negedge osc_in);
    check_vec(tag, 0, lat, v.op);
    obs = -1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge osc_in); #1;
      if (!v.hold) cmd_valid = 0;
      dut_rdy = rdyv(k, v.fall, v.rise);
      if (k == abort_k) rst = 1;
      if (k == 1) begin
        m_xa = v.xa; m_bs = v.bs; m_to = 0;
        if (v.op == LOAD) begin m_do = v.data; m_oe = 1; end
        if (v.op == READ) m_oe = 0;
      end
      if (k == lat) begin
        if (v.op == READ) m_rd = v.din;
        if (v.op == PROG) m_to = to;
      end
      @(negedge osc_in);
      check_vec(tag, k, lat, v.op);
      if (rsp_valid && obs < 0) obs = k;
      if (k == abort_k) begin
        model_reset();
        return;
      end
    end
    chk($sformatf("%s latency", tag), 32'(obs), 32'(v.lat));
    chk($sformatf("%s timeout", tag), 32'(rsp_timeout), 32'(v.to));
    dut_rdy = 1;
    for (int g = 1; g <= gap; g++) begin
      @(posedge osc_in); #1;
      @(negedge osc_in);
      check_vec(tag, lat + g, lat, v.op);
    end
  endtask

  task automatic step();
    @(posedge osc_in); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int lat;
    bit to;
    tbl[0]  = '{LOAD,  2'b00, 2'b00, 8'hA5, 8'h00, 3, 1000,   0, 7,   0};
    tbl[1]  = '{PROG,  2'b01, 2'b10, 8'h00, 8'h00, 4, 40,     0, 43,  0};
    tbl[2]  = '{PROG,  2'b11, 2'b01, 8'h00, 8'h00, 3, 100000, 0, 107, 1};
    tbl[3]  = '{LOAD,  2'b10, 2'b01, 8'h5A, 8'h00, 3, 1000,   0, 7,   0};
    tbl[4]  = '{READ,  2'b00, 2'b00, 8'h00, 8'h3C, 3, 1000,   0, 6,   0};
    tbl[5]  = '{PAGEL, 2'b01, 2'b11, 8'h00, 8'h00, 3, 1000,   1, 7,   0};
    tbl[6]  = '{READ,  2'b10, 2'b10, 8'h00, 8'hC3, 3, 1000,   1, 6,   0};
    tbl[7]  = '{LOAD,  2'b01, 2'b00, 8'hFF, 8'h00, 3, 1000,   0, 7,   0};
    tbl[8]  = '{PROG,  2'b00, 2'b11, 8'h00, 8'h00, 5, 104,    0, 107, 0};
    tbl[9]  = '{PROG,  2'b10, 2'b00, 8'h00, 8'h00, 3, 103,    0, 106, 0};
    tbl[10] = '{PROG,  2'b01, 2'b01, 8'h00, 8'h00, 7, 30,     0, 33,  0};

    rst = 1; cmd_valid = 0; cmd_op = '0; cmd_xa = '0; cmd_bs = '0;
    cmd_data = '0; dut_data_i = '0; dut_rdy = 1;
    model_reset();
    repeat (2) @(posedge osc_in);
    @(negedge osc_in);
    check_vec("reset", 0, 1, LOAD);
    step();
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      step();
      run_cmd($sformatf("tbl%0d", i), tbl[i], tbl[i].hold ? 0 : 1, -1);
    end

    // Reset while PROG waits for RDY, cmd_valid held throughout.
    step();
    v = '{PROG, 2'b11, 2'b11, 8'h00, 8'h00, 3, 100000, 1, 0, 0};
    run_cmd("abort", v, 0, 20);
    step();
    rst = 0;
    dut_rdy = 1;
    v = '{LOAD, 2'b01, 2'b10, 8'h69, 8'h00, 3, 1000, 0, 7, 0};
    run_cmd("post_rst", v, 1, -1);

    for (int i = 0; i < 40; i++) begin
      v.op   = 2'($urandom_range(0, 3));
      v.xa   = 2'($urandom_range(0, 3));
      v.bs   = 2'($urandom_range(0, 3));
      v.data = 8'($urandom_range(0, 255));
      v.din  = 8'($urandom_range(0, 255));
      v.fall = $urandom_range(3, 8);
      v.rise = $urandom_range(9, 130);
      v.hold = ($urandom_range(0, 3) == 0);
      model(v.op, v.fall, v.rise, lat, to);
      v.lat = lat;
      v.to  = to;
      step();
      run_cmd($sformatf("rnd%0d", i), v,
              v.hold ? 0 : $urandom_range(0, 3), -1);
    end

    step();
    cmd_valid = 0;
    @(negedge osc_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
